// File: rtl/channel_pkg.sv
// Shared definitions for the channel lease block: ID geometry, grant layout and FSM states.
package channel_pkg;

    localparam int NUM_ID          = 8;
    localparam int ID_W            = 3;
    localparam int GRANT_VALID_BIT = 3;
    localparam int STAT_W          = 8;

    localparam logic [STAT_W-1:0] STAT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        LEASE,
        COOLDOWN
    } lease_state_t;

    function automatic logic [NUM_ID-1:0] id_onehot(input logic [ID_W-1:0] id);
        return NUM_ID'(1) << id;
    endfunction

endpackage

// File: rtl/lease_timer.sv
// Loadable down-counter that stops at zero; zero flags the final cycle of a lease.
module lease_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    // NOTE: sequential state is always written with <=; blocking assignments here would race with readers.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/channel_lease.sv
// Time-limited channel lease: one granted ID owns the channel until done or timeout, then cooldown.
// Optional per-ID grant statistics are built when CHANNEL_LEASE_STATS_EN is defined.
module channel_lease
    import channel_pkg::*;
#(
    parameter int LEASE_CYCLES    = 8,
    parameter int COOLDOWN_CYCLES = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [3:0]          grant,
    input  logic [NUM_ID-1:0]   done,
    output logic [NUM_ID-1:0]   ack,
    output logic [ID_W-1:0]     owner,
    output logic                busy,
    output logic                expired,
    input  logic [ID_W-1:0]     stat_sel,
    output logic [STAT_W-1:0]   stat_count
);

    localparam int TIMER_W = $clog2(LEASE_CYCLES + 1);
    // Timer holds the remaining lease cycles after the current one, so zero marks the last cycle.
    localparam logic [TIMER_W-1:0] LEASE_LOAD = TIMER_W'(LEASE_CYCLES - 1);
    localparam logic [3:0] COOL_LOAD = (COOLDOWN_CYCLES == 0) ? 4'd0 : 4'(COOLDOWN_CYCLES - 1);

    lease_state_t    state;
    logic [3:0]      cool_cnt;
    logic            grant_valid;
    logic [ID_W-1:0] grant_id;
    logic            accept;
    logic            owner_done;
    logic            timer_zero;

    assign grant_valid = grant[GRANT_VALID_BIT];
    assign grant_id    = grant[ID_W-1:0];
    assign accept      = (state == IDLE) && grant_valid;
    assign owner_done  = done[owner];

    lease_timer #(
        .WIDTH (TIMER_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .load_val (LEASE_LOAD),
        .en       (state == LEASE),
        .zero     (timer_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ack      <= '0;
            owner    <= '0;
            busy     <= 1'b0;
            expired  <= 1'b0;
            cool_cnt <= '0;
        end else begin
            expired <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        state <= LEASE;
                        owner <= grant_id;
                        ack   <= id_onehot(grant_id);
                        busy  <= 1'b1;
                    end
                end
                LEASE: begin
                    // A release on the final lease cycle wins over the timeout.
                    if (owner_done || timer_zero) begin
                        ack     <= '0;
                        expired <= !owner_done;
                        if (COOLDOWN_CYCLES == 0) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state    <= COOLDOWN;
                            cool_cnt <= COOL_LOAD;
                        end
                    end
                end
                COOLDOWN: begin
                    if (cool_cnt == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cool_cnt <= cool_cnt - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    ack   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef CHANNEL_LEASE_STATS_EN
    logic [STAT_W-1:0] grant_cnt [NUM_ID];

    // NOTE: the counter array is cleared on reset because it is architectural state, not bulk storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_ID; i++) begin
                grant_cnt[i] <= '0;
            end
        end else if (accept && grant_cnt[grant_id] != STAT_MAX) begin
            grant_cnt[grant_id] <= grant_cnt[grant_id] + 1'b1;
        end
    end

    assign stat_count = grant_cnt[stat_sel];
`else
    logic unused_stat_sel;

    assign unused_stat_sel = ^stat_sel;
    assign stat_count      = '0;
`endif

endmodule

// File: tb/tb_channel_lease.sv
// Scoreboard bench for channel_lease: an interval-based lease model predicts each cycle's outputs.
module tb_channel_lease;

    localparam int L0 = 8;
    localparam int C0 = 1;
    localparam int L1 = 1;
    localparam int C1 = 0;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] grant;
    logic [7:0] done;
    logic [2:0] stat_sel;

    logic [7:0] ack0, ack1, stat0, stat1;
    logic [2:0] owner0, owner1;
    logic       busy0, busy1, expired0, expired1;

    always #5 clk = ~clk;

    channel_lease #(.LEASE_CYCLES(L0), .COOLDOWN_CYCLES(C0)) dut0 (
        .clk(clk), .rst(rst), .grant(grant), .done(done), .ack(ack0), .owner(owner0),
        .busy(busy0), .expired(expired0), .stat_sel(stat_sel), .stat_count(stat0)
    );

    channel_lease #(.LEASE_CYCLES(L1), .COOLDOWN_CYCLES(C1)) dut1 (
        .clk(clk), .rst(rst), .grant(grant), .done(done), .ack(ack1), .owner(owner1),
        .busy(busy1), .expired(expired1), .stat_sel(stat_sel), .stat_count(stat1)
    );

    // Lease described as cycle intervals: ack over [astart, alast], busy over [astart, blast].
    typedef struct packed {
        int              own;
        int              astart;
        int              alast;
        int              blast;
        int              expc;
        logic [7:0][7:0] cnt;
    } model_t;

    typedef struct packed {
        logic [7:0] ack;
        logic [2:0] owner;
        logic       own_chk;
        logic       busy;
        logic       expired;
        logic [7:0] stat;
    } exp_t;

    model_t m0, m1;
    exp_t   q0[$];
    exp_t   q1[$];
    int     t = 0;
    int     errors = 0;
    int     checks = 0;

    function automatic void model_step(inout model_t m, input int tc, input logic r,
                                       input logic [3:0] g, input logic [7:0] d,
                                       input int lc, input int cc);
        int id;
        if (r) begin
            m.own = 0; m.astart = 0; m.alast = -1; m.blast = -1; m.expc = -1; m.cnt = '0;
        end else if (m.blast < tc - 1) begin
            if (g[3]) begin
                id = int'(g[2:0]);
                m.own = id; m.astart = tc; m.alast = tc + lc - 1;
                m.blast = tc + lc - 1 + cc; m.expc = tc + lc;
                if (m.cnt[id] != 8'd255) m.cnt[id] = m.cnt[id] + 8'd1;
            end
        end else if (tc - 1 >= m.astart && tc - 1 <= m.alast && d[m.own]) begin
            m.alast = tc - 1; m.blast = tc - 1 + cc; m.expc = -1;
        end
    endfunction

    function automatic exp_t model_out(input model_t m, input int tc, input logic r, input logic [2:0] sel);
        exp_t e;
        e.busy    = (tc >= m.astart) && (tc <= m.blast);
        e.ack     = (tc >= m.astart && tc <= m.alast) ? (8'd1 << m.own) : 8'd0;
        e.expired = (tc == m.expc);
        e.owner   = 3'(m.own);
        e.own_chk = e.busy || r;
`ifdef CHANNEL_LEASE_STATS_EN
        e.stat    = m.cnt[sel];
`else
        e.stat    = 8'd0;
`endif
        return e;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, expv);
        end
    endtask

    task automatic compare(input string tag, input logic [7:0] a, input logic [2:0] o, input logic b,
                           input logic x, input logic [7:0] s, input exp_t e);
        check({tag, "_ack"}, a, e.ack);
        check({tag, "_busy"}, 8'(b), 8'(e.busy));
        check({tag, "_expired"}, 8'(x), 8'(e.expired));
        check({tag, "_stat"}, s, e.stat);
        if (e.own_chk) check({tag, "_owner"}, 8'(o), 8'(e.owner));
    endtask

    // One call per clock edge: apply inputs, predict the post-edge outputs, queue them.
    task automatic cycle(input logic r, input logic [3:0] g, input logic [7:0] d, input logic [2:0] sel);
        rst = r; grant = g; done = d; stat_sel = sel;
        model_step(m0, t, r, g, d, L0, C0);
        q0.push_back(model_out(m0, t, r, sel));
        model_step(m1, t, r, g, d, L1, C1);
        q1.push_back(model_out(m1, t, r, sel));
        t++;
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 4'b0000, 8'h00, 3'($urandom));
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q0.size() > 0) begin
                e = q0.pop_front();
                compare("d0", ack0, owner0, busy0, expired0, stat0, e);
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                compare("d1", ack1, owner1, busy1, expired1, stat1, e);
            end
        end
    end

    initial begin : driver
        logic [7:0] d;
        logic [3:0] g;
        cycle(1'b1, 4'b0000, 8'h00, 3'd0);
        cycle(1'b1, 4'b1111, 8'hFF, 3'd1);

        // ID5 lease runs to timeout.
        cycle(1'b0, 4'b1101, 8'h00, 3'd5);
        idle(12);

        // ID2 released by done on its third lease cycle.
        cycle(1'b0, 4'b1010, 8'h00, 3'd2);
        idle(2);
        cycle(1'b0, 4'b0000, 8'h04, 3'd2);
        idle(4);

        // Foreign grant and done during an ID5 lease change nothing.
        cycle(1'b0, 4'b1101, 8'h00, 3'd5);
        for (int i = 0; i < 4; i++) cycle(1'b0, 4'b1011, 8'h08, 3'd3);
        idle(8);

        // Reset on the fourth lease cycle, then a fresh grant for ID7.
        cycle(1'b0, 4'b1101, 8'h00, 3'd5);
        idle(3);
        cycle(1'b1, 4'b0000, 8'h00, 3'd5);
        cycle(1'b0, 4'b1111, 8'h00, 3'd7);
        idle(11);

        // Valid-low grants with junk ID bits must be ignored.
        for (int i = 0; i < 8; i++) cycle(1'b0, 4'(i), 8'h00, 3'(i));

        // Alternating ID0/ID1 grants; the short-lease instance pulses ack each lease.
        for (int i = 0; i < 8; i++) cycle(1'b0, (i % 4 < 2) ? 4'b1000 : 4'b1001, 8'h00, 3'($urandom));
        idle(12);

        for (int i = 0; i < 2000; i++) begin
            g = ($urandom_range(0, 2) == 0) ? {1'b1, 3'($urandom)} : {1'b0, 3'($urandom)};
            d = 8'h00;
            for (int b = 0; b < 8; b++) d[b] = ($urandom_range(0, 15) == 0);
            cycle($urandom_range(0, 199) == 0, g, d, 3'($urandom));
        end

`ifdef CHANNEL_LEASE_STATS_EN
        cycle(1'b1, 4'b0000, 8'h00, 3'd4);
        for (int i = 0; i < 1000; i++) cycle(1'b0, 4'b1100, 8'h10, 3'($urandom));
        idle(12);
        cycle(1'b0, 4'b0000, 8'h00, 3'd4);
        cycle(1'b0, 4'b0000, 8'h00, 3'd0);
`endif

        idle(2);
        @(negedge clk);
        #1;
        check("sb_drain0", 8'(q0.size()), 8'd0);
        check("sb_drain1", 8'(q1.size()), 8'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
